// File: rtl/cpu_fetch_unit.sv
// rtl/cpu_fetch_unit.sv - PC owner and prefetch buffer between instruction memory and decode
// Optional CPU_FETCH_PERF_EN adds perf_fetched / perf_dropped counters.

module cpu_fetch_unit #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          IMEM_AW    = 8,
  parameter logic [31:0] RESET_VEC  = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC    = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC    = 32'h8000_0008
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [IMEM_AW:0] imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             redir_valid,
  input  logic             redir_is_jr,
  input  logic [31:0]      redir_target,
  input  logic             irq,
  input  logic             exc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst_data,
  output logic [31:0]      inst_pc,
  output logic [31:0]      inst_pc_plus4,
  output logic             trap_taken,
  output logic [31:0]      epc
`ifdef CPU_FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_dropped
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   pc, pc_next;
  logic          epoch;
  logic          inflight, inflight_epoch;
  logic [31:0]   inflight_pc;
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_next;
  logic [CW:0]   occupancy;
  logic [31:0]   redir_pc, epc_next;
  logic          kmode, pop, push, flush, req, tag_match;
  logic          take_exc, take_irq;

  // ---------------- next-state logic ----------------
  always_comb begin
    kmode     = pc[31];
    pop       = (count != '0) && inst_ready;
    take_exc  = exc;
    take_irq  = irq && !kmode && !exc;
    flush     = take_exc || take_irq || redir_valid;
    tag_match = inflight && (inflight_epoch == epoch);
    // A response landing in a flush cycle belongs to the old path.
    push      = tag_match && !flush;
    occupancy = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
    req       = (occupancy < (CW+1)'(FIFO_DEPTH)) && !flush;

    // Only jr may drop to user mode; nothing but a trap re-enters kernel.
    redir_pc  = {(redir_is_jr ? (kmode & redir_target[31]) : kmode), redir_target[30:0]};

    pc_next = pc;
    if (take_exc)
      pc_next = EXC_VEC;
    else if (take_irq)
      pc_next = IRQ_VEC;
    else if (redir_valid)
      pc_next = redir_pc;
    else if (req)
      pc_next = {pc[31], pc[30:0] + 31'd4};

    count_next = count + CW'(push) - CW'(pop);
    if (flush)
      count_next = '0;
  end

  always_comb begin
    epc_next = epc;
    if (take_exc)
      epc_next = inst_pc_plus4;
    else if (take_irq) begin
      if (redir_valid)
        epc_next = redir_pc;
      else if (inst_valid && !pop)
        epc_next = inst_pc;
      else if (pop)
        epc_next = inst_pc_plus4;
      else
        epc_next = pc;
    end
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc             <= RESET_VEC;
      epoch          <= 1'b0;
      inflight       <= 1'b0;
      inflight_epoch <= 1'b0;
      inflight_pc    <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      epc            <= '0;
    end else begin
      pc             <= pc_next;
      epoch          <= flush ? ~epoch : epoch;
      inflight       <= req;
      inflight_epoch <= epoch;
      if (req)
        inflight_pc <= pc;
      count <= count_next;
      epc   <= epc_next;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PW'(1);
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= inflight_pc;
    end
  end

`ifdef CPU_FETCH_PERF_EN
  logic          drop_resp;
  logic [CW-1:0] cleared;

  always_comb begin
    drop_resp = inflight && (!tag_match || flush);
    cleared   = flush ? (count - CW'(pop)) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(push);
      perf_dropped <= perf_dropped + 32'(drop_resp) + 32'(cleared);
    end
  end
`endif

  // ---------------- outputs ----------------
  always_comb begin
    imem_req      = req && !reset;
    imem_addr     = {pc[31], pc[IMEM_AW+1:2]};
    inst_valid    = (count != '0);
    inst_data     = inst_valid ? fifo_data[rd_ptr] : '0;
    inst_pc       = inst_valid ? fifo_pc[rd_ptr] : '0;
    inst_pc_plus4 = {inst_pc[31], inst_pc[30:0] + 31'd4};
    trap_taken    = (take_exc || take_irq) && !reset;
  end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// tb/tb_cpu_fetch_unit.sv - directed self-checking bench for cpu_fetch_unit
// Memory model returns the 9-bit word address as data.

module tb_cpu_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redir_valid = 1'b0;
  logic        redir_is_jr = 1'b0;
  logic [31:0] redir_target = '0;
  logic        irq = 1'b0;
  logic        exc = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data, inst_pc, inst_pc_plus4, epc;
  logic        trap_taken;
`ifdef CPU_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif

  int errors = 0;
  int checks = 0;

  cpu_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redir_valid(redir_valid), .redir_is_jr(redir_is_jr), .redir_target(redir_target),
    .irq(irq), .exc(exc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_pc_plus4(inst_pc_plus4),
    .trap_taken(trap_taken), .epc(epc)
`ifdef CPU_FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (imem_req)
      imem_rdata <= {23'd0, imem_addr};

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redir_valid = 1'b0; redir_is_jr = 1'b0; redir_target = '0;
    irq = 1'b0; exc = 1'b0; inst_ready = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    next_cycle();
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req got=%0b exp=0", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got=%0b exp=0", inst_valid); end
    checks++; if (trap_taken !== 1'b0) begin errors++; $display("FAIL reset_trap_taken got=%0b exp=0", trap_taken); end
    checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc got=%h exp=0", epc); end
    checks++; if (inst_data !== 32'h0) begin errors++; $display("FAIL reset_inst_data got=%h exp=0", inst_data); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got=%h exp=0", inst_pc); end
  endtask

  task automatic test_sequential();
    logic [8:0] exp_addr;
    do_reset();
    inst_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) next_cycle();
      #1;
      exp_addr = 9'h100 + 9'(c);
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
        errors++; $display("FAIL seq_req c=%0d got=%0b/%h exp=1/%h", c, imem_req, imem_addr, exp_addr); end
      if (c >= 2) begin
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0000 + 32'(4*(c-2)) || inst_data !== 32'h100 + 32'(c-2)) begin
          errors++; $display("FAIL seq_inst c=%0d got=%0b/%h/%h exp=1/%h/%h", c, inst_valid, inst_pc, inst_data,
                             32'h8000_0000 + 32'(4*(c-2)), 32'h100 + 32'(c-2)); end
      end
    end
  endtask

  task automatic test_backpressure();
    int nreq = 0;
    do_reset();
    inst_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) next_cycle();
      #1;
      if (imem_req === 1'b1) nreq++;
    end
    checks++; if (nreq != 4) begin errors++; $display("FAIL bp_req_count got=%0d exp=4", nreq); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_stalled got=%0b exp=0", imem_req); end
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      inst_ready = 1'b1;
      #1;
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0000 + 32'(4*k) || inst_data !== 32'h100 + 32'(k)) begin
        errors++; $display("FAIL bp_resume k=%0d got=%0b/%h/%h exp=1/%h/%h", k, inst_valid, inst_pc, inst_data,
                           32'h8000_0000 + 32'(4*k), 32'h100 + 32'(k)); end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    inst_ready = 1'b1;
    repeat (4) next_cycle();
    redir_valid = 1'b1; redir_is_jr = 1'b1; redir_target = 32'h0000_0040;
    #1;
    checks++; if (trap_taken !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL jr_flush_cycle got trap=%0b req=%0b exp=0/0", trap_taken, imem_req); end
    next_cycle();
    redir_valid = 1'b0; redir_is_jr = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 9'h010 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL jr_t1 got=%0b/%h/%0b exp=1/010/0", imem_req, imem_addr, inst_valid); end
    next_cycle();
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL jr_t2_valid got=%0b exp=0", inst_valid); end
    next_cycle();
    redir_valid = 1'b1; redir_is_jr = 1'b0; redir_target = 32'h8000_0010;
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0000_0040 || inst_data !== 32'h10) begin
      errors++; $display("FAIL jr_t3 got=%0b/%h/%h exp=1/00000040/00000010", inst_valid, inst_pc, inst_data); end
    next_cycle();
    redir_valid = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL jmp_t1_valid got=%0b exp=0", inst_valid); end
    next_cycle();
    next_cycle();
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0000_0010 || inst_data !== 32'h4) begin
      errors++; $display("FAIL jmp_user_t3 got=%0b/%h/%h exp=1/00000010/00000004", inst_valid, inst_pc, inst_data); end
  endtask

  task automatic test_irq();
    do_reset();
    inst_ready = 1'b0;
    redir_valid = 1'b1; redir_is_jr = 1'b1; redir_target = 32'h0000_0050;
    next_cycle();
    redir_valid = 1'b0; redir_is_jr = 1'b0;
    next_cycle();
    next_cycle();
    irq = 1'b1;
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0000_0050 || trap_taken !== 1'b1) begin
      errors++; $display("FAIL irq_take got=%0b/%h/%0b exp=1/00000050/1", inst_valid, inst_pc, trap_taken); end
    next_cycle();
    inst_ready = 1'b1;
    #1;
    checks++; if (epc !== 32'h0000_0050) begin errors++; $display("FAIL irq_epc got=%h exp=00000050", epc); end
    for (int c = 4; c < 8; c++) begin
      if (c > 4) next_cycle();
      #1;
      checks++; if (trap_taken !== 1'b0) begin errors++; $display("FAIL irq_kernel_mask c=%0d got=%0b exp=0", c, trap_taken); end
      if (c == 6) begin
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0004 || inst_data !== 32'h101) begin
          errors++; $display("FAIL irq_vector got=%0b/%h/%h exp=1/80000004/00000101", inst_valid, inst_pc, inst_data); end
      end
    end
    irq = 1'b0;
  endtask

  task automatic test_exc();
    do_reset();
    inst_ready = 1'b0;
    redir_valid = 1'b1; redir_is_jr = 1'b1; redir_target = 32'h0000_0020;
    next_cycle();
    redir_valid = 1'b0; redir_is_jr = 1'b0;
    next_cycle();
    next_cycle();
    exc = 1'b1; irq = 1'b1; redir_valid = 1'b1; redir_target = 32'h0000_0300;
    #1;
    checks++; if (inst_pc !== 32'h0000_0020 || trap_taken !== 1'b1) begin
      errors++; $display("FAIL exc_take got=%h/%0b exp=00000020/1", inst_pc, trap_taken); end
    next_cycle();
    exc = 1'b0; irq = 1'b0; redir_valid = 1'b0; inst_ready = 1'b1;
    #1;
    checks++; if (epc !== 32'h0000_0024) begin errors++; $display("FAIL exc_epc got=%h exp=00000024", epc); end
    next_cycle();
    next_cycle();
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0008 || inst_data !== 32'h102) begin
      errors++; $display("FAIL exc_vector got=%0b/%h/%h exp=1/80000008/00000102", inst_valid, inst_pc, inst_data); end
  endtask

  task automatic test_stale_drop();
    do_reset();
    inst_ready = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 9'h100) begin
      errors++; $display("FAIL stale_req got=%0b/%h exp=1/100", imem_req, imem_addr); end
    next_cycle();
    redir_valid = 1'b1; redir_is_jr = 1'b0; redir_target = 32'h8000_0020;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stale_flush_req got=%0b exp=0", imem_req); end
    next_cycle();
    redir_valid = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stale_t1_valid got=%0b data=%h exp=0", inst_valid, inst_data); end
`ifdef CPU_FETCH_PERF_EN
    checks++; if (perf_dropped !== 32'd1) begin errors++; $display("FAIL perf_dropped got=%0d exp=1", perf_dropped); end
`endif
    next_cycle();
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stale_t2_valid got=%0b data=%h exp=0", inst_valid, inst_data); end
    next_cycle();
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0020 || inst_data !== 32'h108) begin
      errors++; $display("FAIL stale_target got=%0b/%h/%h exp=1/80000020/00000108", inst_valid, inst_pc, inst_data); end
`ifdef CPU_FETCH_PERF_EN
    checks++; if (perf_fetched !== 32'd1) begin errors++; $display("FAIL perf_fetched got=%0d exp=1", perf_fetched); end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_irq();
    test_exc();
    test_stale_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
